// File: rtl/stopwatch_controller.sv
// ---------------------------------------------------------------------------
// stopwatch_controller
//
// Sequencing controller for the stopwatch time datapath. Holds the
// STOP/RUN/CLEAR state machine, divides the system clock down to a
// centisecond tick, and keeps the centisecond (0-99) and second (0-59)
// counters that feed the digit-divider stage.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   : i_btn_lap toggles a lap hold that freezes o_sec/o_msec on a
//               snapshot while the internal counters keep running.
//   undefined : i_btn_lap is ignored, o_lap is 0, no snapshot registers.
//
// Parameters
//   DIV            system-clock cycles per centisecond tick (>= 2)
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   i_btn_run_stop single-cycle pulse: toggle RUN/STOP
//   i_btn_clear    single-cycle pulse: zero counters and stop
//   i_btn_lap      single-cycle pulse: toggle lap hold (lap build only)
//   o_sec          displayed seconds, 0-59
//   o_msec         displayed centiseconds, 0-99 (upper bits always 0)
//   o_run          1 while in RUN
//   o_lap          1 while lap hold is active
//   o_sec_wrap     one-cycle pulse after seconds wrap 59 -> 0
// ---------------------------------------------------------------------------
module stopwatch_controller #(
    parameter int DIV = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_run_stop,
    input  logic       i_btn_clear,
    input  logic       i_btn_lap,
    output logic [5:0] o_sec,
    output logic [9:0] o_msec,
    output logic       o_run,
    output logic       o_lap,
    output logic       o_sec_wrap
);

    localparam int              DIV_W    = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [6:0]       msec_q, msec_d;
    logic [5:0]       sec_q, sec_d;
    logic             wrap_q, wrap_d;

    logic counting;  // RUN with no button pulse this cycle
    logic tick;
    logic wipe;      // counters forced to zero this edge

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOP: begin
                if (i_btn_clear)         state_d = ST_CLEAR;
                else if (i_btn_run_stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_btn_clear)         state_d = ST_CLEAR;
                else if (i_btn_run_stop) state_d = ST_STOP;
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    // A tick that lands on a stop or clear pulse is dropped, and the divider
    // returns to 0 so the next RUN segment starts a full tick period.
    assign counting = (state_q == ST_RUN) && !i_btn_run_stop && !i_btn_clear;
    assign tick     = counting && (div_q == DIV_LAST);
    // Clear is accepted from STOP/RUN; in CLEAR itself the zeroing repeats.
    assign wipe     = i_btn_clear || (state_q == ST_CLEAR);

    always_comb begin
        div_d  = '0;
        msec_d = msec_q;
        sec_d  = sec_q;
        wrap_d = 1'b0;
        if (counting && !tick) begin
            div_d = div_q + 1'b1;
        end
        if (wipe) begin
            msec_d = '0;
            sec_d  = '0;
        end else if (tick) begin
            if (msec_q == 7'd99) begin
                msec_d = '0;
                if (sec_q == 6'd59) begin
                    sec_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end else begin
                msec_d = msec_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STOP;
            div_q   <= '0;
            msec_q  <= '0;
            sec_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            msec_q  <= msec_d;
            sec_q   <= sec_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_run      = (state_q == ST_RUN);
    assign o_sec_wrap = wrap_q;

`ifdef STOPWATCH_LAP_EN
    logic       lap_q, lap_d;
    logic [6:0] snap_msec_q, snap_msec_d;
    logic [5:0] snap_sec_q, snap_sec_d;

    // The snapshot takes the value the live counters assume at the lap
    // edge, so the display freezes on exactly what it would have shown.
    always_comb begin
        lap_d       = lap_q;
        snap_msec_d = snap_msec_q;
        snap_sec_d  = snap_sec_q;
        if (wipe) begin
            lap_d = 1'b0;
        end else if (i_btn_lap) begin
            if (state_q == ST_RUN) begin
                lap_d = !lap_q;
                if (!lap_q) begin
                    snap_msec_d = msec_d;
                    snap_sec_d  = sec_d;
                end
            end else begin
                lap_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_q       <= 1'b0;
            snap_msec_q <= '0;
            snap_sec_q  <= '0;
        end else begin
            lap_q       <= lap_d;
            snap_msec_q <= snap_msec_d;
            snap_sec_q  <= snap_sec_d;
        end
    end

    assign o_lap  = lap_q;
    assign o_sec  = lap_q ? snap_sec_q : sec_q;
    assign o_msec = {3'b000, (lap_q ? snap_msec_q : msec_q)};
`else
    logic unused_lap;
    assign unused_lap = i_btn_lap;

    assign o_lap  = 1'b0;
    assign o_sec  = sec_q;
    assign o_msec = {3'b000, msec_q};
`endif

endmodule

// File: tb/tb_stopwatch_controller.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_controller
//
// Directed bench for stopwatch_controller (DIV = 4). A behavioural model
// tracks elapsed time as a single centisecond total and the time spent in
// the current RUN segment; a negedge process compares every output against
// it each cycle, and literal expectations pin the key timing points.
// Works with or without STOPWATCH_LAP_EN defined.
// ---------------------------------------------------------------------------
module tb_stopwatch_controller;

    localparam int DIV      = 4;
    localparam int FULL_CS  = 6000;  // 60.00 s
    localparam int ADV_MAX  = 30000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_rs = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_lap = 1'b0;
    logic [5:0] o_sec;
    logic [9:0] o_msec;
    logic       o_run;
    logic       o_lap;
    logic       o_sec_wrap;

    stopwatch_controller #(.DIV(DIV)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_btn_run_stop (btn_rs),
        .i_btn_clear    (btn_clr),
        .i_btn_lap      (btn_lap),
        .o_sec          (o_sec),
        .o_msec         (o_msec),
        .o_run          (o_run),
        .o_lap          (o_lap),
        .o_sec_wrap     (o_sec_wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual,
                     expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit running;
        bit clearing;
        int total_cs;    // elapsed time in centiseconds, 0..5999
        int run_cycles;  // cycles completed in the current RUN segment
        bit lap;
        int snap_cs;
        bit wrap;
    } model_t;

    model_t m;
    bit     cmp_en = 1'b0;

    function automatic model_t model_zero();
        model_t z;
        z.running    = 1'b0;
        z.clearing   = 1'b0;
        z.total_cs   = 0;
        z.run_cycles = 0;
        z.lap        = 1'b0;
        z.snap_cs    = 0;
        z.wrap       = 1'b0;
        return z;
    endfunction

    function automatic model_t model_next(model_t s, bit rst, bit rs, bit clr,
                                          bit lap_b);
        model_t n;
        n = s;
        n.wrap = 1'b0;
        if (rst) begin
            n = model_zero();
        end else if (s.clearing) begin
            n = model_zero();
        end else if (clr) begin
            n = model_zero();
            n.clearing = 1'b1;
        end else begin
            // A centisecond elapses after every DIV uninterrupted RUN cycles.
            if (s.running && !rs && (s.run_cycles % DIV) == DIV - 1) begin
                n.wrap     = (s.total_cs == FULL_CS - 1);
                n.total_cs = (s.total_cs + 1) % FULL_CS;
            end
            n.run_cycles = (s.running && !rs) ? s.run_cycles + 1 : 0;
`ifdef STOPWATCH_LAP_EN
            if (lap_b) begin
                if (s.running) begin
                    n.lap     = !s.lap;
                    n.snap_cs = n.total_cs;
                end else begin
                    n.lap = 1'b0;
                end
            end
`endif
            if (rs) n.running = !s.running;
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m, reset, btn_rs, btn_clr, btn_lap);

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic int shown = m.lap ? m.snap_cs : m.total_cs;
            check("cmp_o_sec", 32'(o_sec), 32'(shown / 100));
            check("cmp_o_msec", 32'(o_msec), 32'(shown % 100));
            check("cmp_o_run", 32'(o_run), 32'(m.running));
            check("cmp_o_lap", 32'(o_lap), 32'(m.lap));
            check("cmp_o_sec_wrap", 32'(o_sec_wrap), 32'(m.wrap));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input bit rs, input bit clr, input bit lap_b);
        btn_rs  = rs;
        btn_clr = clr;
        btn_lap = lap_b;
        @(posedge clk);
        #1;
        btn_rs  = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic advance_to(input int cs);
        int n;
        n = 0;
        while (m.total_cs != cs && n < ADV_MAX) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("advance_to_timeout", 32'(n < ADV_MAX), 32'd1);
    endtask

    task automatic check_time(input string tag, input int sec, input int cs);
        check({tag, "_sec"}, 32'(o_sec), 32'(sec));
        check({tag, "_msec"}, 32'(o_msec), 32'(cs));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check_time("reset", 0, 0);
        check("reset_run", 32'(o_run), 32'd0);
        check("reset_lap", 32'(o_lap), 32'd0);
        check("reset_wrap", 32'(o_sec_wrap), 32'd0);
        reset = 1'b0;

        // Start: o_run at once, first increment DIV edges later
        pulse(1'b1, 1'b0, 1'b0);
        check("start_run", 32'(o_run), 32'd1);
        idle(3);
        check_time("pre_tick1", 0, 0);
        idle(1);
        check_time("tick1", 0, 1);
        idle(4);
        check_time("tick2", 0, 2);

        // Carry into seconds
        advance_to(100);
        check_time("carry", 1, 0);

        // Stop at 3.42, hold, resume
        advance_to(342);
        pulse(1'b1, 1'b0, 1'b0);
        check("stop_run", 32'(o_run), 32'd0);
        idle(50);
        check_time("held", 3, 42);
        pulse(1'b1, 1'b0, 1'b0);
        check("resume_run", 32'(o_run), 32'd1);
        idle(3);
        check_time("resume_pre", 3, 42);
        idle(1);
        check_time("resume_tick", 3, 43);

        // Full wrap 59.99 -> 0.00
        advance_to(5999);
        check_time("at_5999", 59, 99);
        idle(3);
        check("prewrap_pulse", 32'(o_sec_wrap), 32'd0);
        idle(1);
        check_time("wrapped", 0, 0);
        check("wrap_pulse", 32'(o_sec_wrap), 32'd1);
        idle(1);
        check("wrap_pulse_end", 32'(o_sec_wrap), 32'd0);

        // Clear together with run_stop at 1.05
        advance_to(105);
        check_time("pre_clear", 1, 5);
        pulse(1'b1, 1'b1, 1'b0);
        check_time("cleared", 0, 0);
        check("clear_run", 32'(o_run), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);  // lands in CLEAR: ignored
        check("after_clear_run", 32'(o_run), 32'd0);
        idle(2);
        check("stop_after_clear", 32'(o_run), 32'd0);
        check_time("stop_after_clear", 0, 0);

        // Lap hold at 2.10
        pulse(1'b1, 1'b0, 1'b0);
        advance_to(210);
        pulse(1'b0, 1'b0, 1'b1);
        advance_to(250);
`ifdef STOPWATCH_LAP_EN
        check_time("lap_frozen", 2, 10);
        check("lap_on", 32'(o_lap), 32'd1);
`else
        check_time("lap_ignored", 2, 50);
        check("lap_off", 32'(o_lap), 32'd0);
`endif
        pulse(1'b0, 1'b0, 1'b1);
        check_time("lap_release", 2, 50);
        check("lap_released", 32'(o_lap), 32'd0);

        // Reset mid-RUN at 7.33 with the divider at 2
        advance_to(733);
        idle(2);
        check_time("pre_reset", 7, 33);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_time("mid_reset", 0, 0);
        check("mid_reset_run", 32'(o_run), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        idle(3);
        check_time("post_reset_pre", 0, 0);
        idle(1);
        check_time("post_reset_tick", 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Sequencing controller for the stopwatch time datapath. It holds the run/stop/clear state machine, derives a 10 ms tick from the system clock, and maintains the centisecond (0–99) and second (0–59) counters. Its `o_sec` and `o_msec` outputs feed the seconds/centiseconds digit-divider stage directly. An optional lap-hold feature freezes the displayed time while counting continues.

## Interface
- `DIV`, default 1_000_000: system-clock cycles per centisecond tick (100 MHz / 100 Hz); must be ≥ 2.
- `clk`  input  1  system clock; all logic rising-edge.
- `reset`  input  1  synchronous, active-high reset.
- `i_btn_run_stop`  input  1  single-cycle pulse (debounced upstream): toggle RUN/STOP.
- `i_btn_clear`  input  1  single-cycle pulse: zero the counters and stop.
- `i_btn_lap`  input  1  single-cycle pulse: toggle lap hold (used only with `STOPWATCH_LAP_EN`).
- `o_sec`  output  6  displayed seconds, 0–59, registered.
- `o_msec`  output  10  displayed centiseconds, 0–99, registered; upper bits always 0.
- `o_run`  output  1  1 while the state is RUN.
- `o_lap`  output  1  1 while lap hold is active.
- `o_sec_wrap`  output  1  one-cycle pulse when seconds wrap 59→0.

## Operation
- States: STOP (reset state), RUN, CLEAR.
- Transitions out of STOP:
  - `i_btn_clear` → CLEAR.
  - else `i_btn_run_stop` → RUN.
- Transitions out of RUN:
  - `i_btn_clear` → CLEAR.
  - else `i_btn_run_stop` → STOP.
- CLEAR → STOP unconditionally after one cycle.
  - In CLEAR: counters, divider and lap flag are zeroed.
  - Button pulses arriving in CLEAR are ignored.
- Priority: clear beats run_stop when both are asserted in the same cycle, in every state.
- Divider `div_cnt` (width `$clog2(DIV)`):
  - Counts 0..DIV-1 only in RUN.
  - Held at 0 in STOP and CLEAR, so every RUN segment starts a fresh tick period.
- Tick edge: state == RUN, `div_cnt == DIV-1`, and no button pulse (run_stop or clear) in that cycle.
  - On a tick edge: `div_cnt` ← 0 and centiseconds increment.
  - A tick coinciding with a stop or clear pulse is dropped.
- Centiseconds 99 → 0 carries into seconds, in the same edge.
- Seconds 59 → 0 (with centiseconds 99 → 0) is a full wrap: both read 0, and `o_sec_wrap` pulses on that edge's following cycle.
- STOP holds the counter values. Re-entering RUN resumes from the held values.

## Timing
- Reset (synchronous, takes priority over everything):
  - State STOP, `div_cnt` 0, counters 0.
  - Outputs: `o_sec` 0, `o_msec` 0, `o_run` 0, `o_lap` 0, `o_sec_wrap` 0.
- Button pulse sampled at edge N → state and `o_run` change at edge N.
  - Visible in cycle N+1.
- First centisecond increment after entering RUN at edge N: occurs at edge N+DIV.
- Subsequent increments: every DIV cycles while RUN is uninterrupted.
- Clear at edge N:
  - Counters read 0 from cycle N+1.
  - State is STOP from edge N+1.
- Reset asserted mid-count: no partial tick survives; the behaviour is identical to power-up.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- Defined — lap hold:
  - `i_btn_lap` in RUN toggles `o_lap`.
  - On entering hold, `o_sec`/`o_msec` latch a snapshot of the internal counters at that edge and stay frozen. Internal counting continues.
  - On leaving hold, the outputs track the live counters again in the next cycle.
  - `i_btn_lap` in STOP clears hold.
  - Clear and reset also clear hold.
  - Clear wins over lap when both are asserted in the same cycle.
- Undefined:
  - `i_btn_lap` is ignored and `o_lap` is tied 0.
  - Outputs always show the live counters.
  - No snapshot registers are synthesized.

## Test plan
- `DIV`=4, reset, run pulse at cycle 10:
  - `o_run`=1 at 11.
  - `o_msec`=1 after edge 14, 2 after edge 18.
- Run for 100 ticks → `o_msec`=0, `o_sec`=1. Preload 59.99 and tick → `o_sec`=0, `o_msec`=0, `o_sec_wrap` high for exactly one cycle.
- Run then stop at 3.42:
  - Values are held for 50 cycles.
  - On resume, the next increment comes exactly DIV cycles later → 3.43.
- Clear and run_stop in the same cycle while RUN at 1.05:
  - Next cycle: 0.00, `o_run`=0.
  - State STOP after CLEAR.
- With `STOPWATCH_LAP_EN`, lap at 2.10:
  - Outputs frozen at 2.10 while internal counting reaches 2.50.
  - Second lap pulse → outputs show 2.50 in the next cycle.
  - Without the macro, the same stimulus → outputs never freeze and `o_lap`=0.
- Reset asserted mid-RUN at 7.33 with `div_cnt`=2 → all outputs 0, `o_run`=0. A subsequent run → first increment DIV cycles later.
